fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Frame sequencer for the parallel fft1024 datapath.
- Collects a serial 16-bit audio sample stream into an FFT-point frame and presents it as a parallel frame on `time_coord`.
- Runs the transform by holding `fft_en` until `fft_valid`, then streams bins 0..OUT_BINS-1 (real, imag) out serially under valid/ready.
- Sits between the audio capture path and spectrum consumers (display/feature logic).

Parameters:
- FFT, 1024, transform size in points (power of 2, ≥4).
- LGFFT, 10, log2(FFT).
- OUT_BINS, FFT/2, bins streamed per frame (1..FFT).
- TIMEOUT, 4096, max cycles in RUN before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  controller accepts sample
- in_sample  in  16  signed audio sample
- time_coord  out  16*FFT  frame; bits [16i+15:16i] = sample i (i=0 is first accepted)
- fft_en  out  1  FFT enable
- fft_valid  in  1  FFT result valid
- fft_re  in  16*FFT  FFT real outputs, same packing as time_coord
- fft_im  in  16*FFT  FFT imag outputs
- out_valid  out  1  bin offered
- out_ready  in  1  consumer accepts bin
- out_idx  out  LGFFT  bin index
- out_re  out  16  bin real
- out_im  out  16  bin imag
- out_last  out  1  high with bin OUT_BINS-1
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset, synchronous, active-high, applies on any cycle including mid-frame:
  - state=COLLECT, write pointer=0, out_idx=0.
  - in_ready=1 from the first cycle after reset; fft_en=0, out_valid=0, out_last=0, frame_cnt=0, timeout_err=0.
  - out_re=out_im=0.
  - Frame buffer contents are not reset.
- States: COLLECT → RUN → DRAIN → COLLECT. All outputs registered or decoded from registered state only; no combinational in→out paths.
- COLLECT:
  - in_ready=1.
  - On in_valid&in_ready, write in_sample to slot wr_ptr and increment wr_ptr.
  - On the accept with wr_ptr=FFT-1: wr_ptr←0 and state←RUN. fft_en=1 on the next cycle; that is 1-cycle latency from the last accept to fft_en.
- RUN:
  - in_ready=0, fft_en=1.
  - time_coord is held constant; the buffer is never written outside COLLECT.
  - fft_valid sampled 1 → next cycle fft_en=0, state=DRAIN, out_valid=1, out_idx=0.
- fft_valid is ignored in COLLECT and DRAIN, including the stale valid that trails fft_en falling.
- DRAIN:
  - out_re/out_im = fft_re/fft_im slice [out_idx].
  - Requires FFT outputs to stay stable while fft_en=0.
  - On out_valid&out_ready: out_idx increments and data updates the next cycle.
  - out_valid stays high with data stable while out_ready=0 (no drop, no duplicate).
  - out_last=1 exactly when out_idx=OUT_BINS-1.
  - Handshake on the last bin: out_valid=0, out_idx=0, frame_cnt+1, state=COLLECT, in_ready=1 the next cycle.
- Input backpressure: samples arriving in RUN/DRAIN stall upstream (in_ready=0); none are lost.
- OUT_BINS=1: the first bin is also last.
- frame_cnt wraps modulo 2^16.

Optional Feature:
- Macro: FFT_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT-1 without fft_valid: next cycle fft_en=0, state=COLLECT (frame discarded, wr_ptr=0), timeout_err=1.
  - timeout_err stays 1 until rst; frame_cnt is unchanged by an aborted frame.
  - fft_valid and expiry in the same cycle: fft_valid wins → DRAIN.
- Undefined: no counter; RUN waits indefinitely; timeout_err tied 0.

Test Plan:
- Fill, FFT=8, OUT_BINS=4, bench FFT stub asserting fft_valid 5 cycles after fft_en and driving re[i]=i*10, im[i]=-i:
  - Feed samples 1..8 back-to-back → time_coord slot i = i+1.
  - fft_en rises 1 cycle after the 8th accept.
  - in_ready=0 during RUN.
- Drain ordering: out_ready=1 → bins (0,0),(1,10,-1),(2,20,-2),(3,30,-3) on consecutive cycles; out_last only on idx 3; frame_cnt=1; in_ready=1 the cycle after.
- Backpressure:
  - Toggle out_ready 1010… → each bin appears exactly once, held stable while stalled.
  - in_valid with gaps during COLLECT → same frame contents.
- Stale valid: stub holds fft_valid 3 cycles after fft_en falls → no second DRAIN, no extra outputs.
- Reset mid-frame: rst during DRAIN at idx 2 → next cycle out_valid=0, frame_cnt=0, in_ready=1. The next full frame streams from idx 0.
- Timeout (FFT_CTRL_TIMEOUT_EN, TIMEOUT=16): stub never asserts fft_valid → fft_en drops after 16 RUN cycles, timeout_err=1, frame_cnt=0, next frame accepted normally.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer for a parallel FFT datapath. It gathers a serial stream of
// signed 16-bit samples into an FFT-point frame, holds fft_en until the FFT
// reports fft_valid, then streams bins 0..OUT_BINS-1 out one per handshake.
//
// Optional build macro: FFT_CTRL_TIMEOUT_EN
//   defined   -> a RUN watchdog aborts the frame after TIMEOUT cycles without
//                fft_valid and sets the sticky timeout_err flag.
//   undefined -> RUN waits indefinitely and timeout_err is tied to 0.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      sample offered          in_ready   controller accepts it
//   in_sample     signed sample
//   time_coord    frame, bits [16i+15:16i] hold sample i (i=0 first accepted)
//   fft_en        FFT enable              fft_valid  FFT result valid
//   fft_re/fft_im FFT outputs, same packing as time_coord
//   out_valid     bin offered             out_ready  consumer accepts it
//   out_idx       bin index               out_re/out_im  bin value
//   out_last      high with bin OUT_BINS-1
//   frame_cnt     completed frames, wraps modulo 2^16
//   timeout_err   sticky abort flag
//   state_dbg     current FSM state (0 COLLECT, 1 RUN, 2 DRAIN)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; once raised, valid and its data stay put until that transfer.
// All outputs come from flops; there is no combinational input->output path.
// ----------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter int FFT      = 1024,
    parameter int LGFFT    = 10,
    parameter int OUT_BINS = FFT / 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_sample,
    output logic [16*FFT-1:0]     time_coord,
    output logic                  fft_en,
    input  logic                  fft_valid,
    input  logic [16*FFT-1:0]     fft_re,
    input  logic [16*FFT-1:0]     fft_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LGFFT-1:0]      out_idx,
    output logic [15:0]           out_re,
    output logic [15:0]           out_im,
    output logic                  out_last,
    output logic [15:0]           frame_cnt,
    output logic                  timeout_err,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_RUN     = 2'd1,
        S_DRAIN   = 2'd2
    } state_e;

    localparam logic [LGFFT-1:0] LAST_SLOT = LGFFT'(FFT - 1);
    localparam logic [LGFFT-1:0] LAST_BIN  = LGFFT'(OUT_BINS - 1);

    state_e              state_q, state_d;
    logic [LGFFT-1:0]    wr_ptr_q, wr_ptr_d;
    logic [16*FFT-1:0]   frame_q, frame_d;
    logic                in_ready_q, in_ready_d;
    logic                fft_en_q, fft_en_d;
    logic                out_valid_q, out_valid_d;
    logic [LGFFT-1:0]    out_idx_q, out_idx_d;
    logic [15:0]         out_re_q, out_re_d;
    logic [15:0]         out_im_q, out_im_d;
    logic                out_last_q, out_last_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]     run_cnt_q, run_cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_d     = frame_q;
        in_ready_d  = in_ready_q;
        fft_en_d    = fft_en_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
`ifdef FFT_CTRL_TIMEOUT_EN
        run_cnt_d     = run_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            S_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    frame_d[{wr_ptr_q, 4'b0000} +: 16] = in_sample;
                    if (wr_ptr_q == LAST_SLOT) begin
                        wr_ptr_d   = '0;
                        state_d    = S_RUN;
                        in_ready_d = 1'b0;
                        fft_en_d   = 1'b1;
`ifdef FFT_CTRL_TIMEOUT_EN
                        run_cnt_d  = '0;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                // fft_valid takes priority over a watchdog expiry in the same cycle.
                if (fft_valid) begin
                    state_d     = S_DRAIN;
                    fft_en_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_re_d    = fft_re[{out_idx_d, 4'b0000} +: 16];
                    out_im_d    = fft_im[{out_idx_d, 4'b0000} +: 16];
                    out_last_d  = (out_idx_d == LAST_BIN);
                end
`ifdef FFT_CTRL_TIMEOUT_EN
                else if (run_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Abort: frame is discarded, collection restarts at slot 0.
                    state_d       = S_COLLECT;
                    fft_en_d      = 1'b0;
                    in_ready_d    = 1'b1;
                    wr_ptr_d      = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
`endif
            end

            S_DRAIN: begin
                // fft_valid is not looked at here, so a trailing valid is harmless.
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_COLLECT;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_idx_d   = '0;
                        in_ready_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        out_idx_d  = out_idx_q + 1'b1;
                        out_re_d   = fft_re[{out_idx_d, 4'b0000} +: 16];
                        out_im_d   = fft_im[{out_idx_d, 4'b0000} +: 16];
                        out_last_d = (out_idx_d == LAST_BIN);
                    end
                end
            end

            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            wr_ptr_q    <= '0;
            in_ready_q  <= 1'b1;
            fft_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
            run_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            in_ready_q  <= in_ready_d;
            fft_en_q    <= fft_en_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FFT_CTRL_TIMEOUT_EN
            run_cnt_q     <= run_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
        // Frame storage carries no reset; only the write pointer is cleared.
        frame_q <= frame_d;
    end

    assign in_ready   = in_ready_q;
    assign time_coord = frame_q;
    assign fft_en     = fft_en_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign out_last   = out_last_q;
    assign frame_cnt  = frame_cnt_q;
    assign state_dbg  = state_q;
`ifdef FFT_CTRL_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl with FFT=8, OUT_BINS=4, TIMEOUT=16.
// The FFT stub raises fft_valid 5 cycles after fft_en rises, keeps it high
// for 3 cycles after fft_en falls, and presents re[i]=i*10, im[i]=-i.
module tb_fft_frame_ctrl;

  localparam int FFT      = 8;
  localparam int LGFFT    = 3;
  localparam int OUT_BINS = 4;
  localparam int TIMEOUT  = 16;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_sample;
  logic [16*FFT-1:0]   time_coord;
  logic                fft_en;
  logic                fft_valid;
  logic [16*FFT-1:0]   fft_re;
  logic [16*FFT-1:0]   fft_im;
  logic                out_valid;
  logic                out_ready;
  logic [LGFFT-1:0]    out_idx;
  logic [15:0]         out_re;
  logic [15:0]         out_im;
  logic                out_last;
  logic [15:0]         frame_cnt;
  logic                timeout_err;
  logic [1:0]          state_dbg;

  int errors;
  int checks;
  int exp_frames;
  bit stub_never;
  int en_cnt;
  int stale_cnt;

  // expected bins: {idx[2:0], re[15:0], im[15:0]}
  logic [34:0] exp_q[$];

  fft_frame_ctrl #(
    .FFT(FFT), .LGFFT(LGFFT), .OUT_BINS(OUT_BINS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .time_coord(time_coord),
    .fft_en(fft_en), .fft_valid(fft_valid), .fft_re(fft_re), .fft_im(fft_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FFT stub, evaluated on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      en_cnt    = 0;
      stale_cnt = 0;
      fft_valid = 1'b0;
    end else if (fft_en) begin
      en_cnt    = en_cnt + 1;
      stale_cnt = 0;
      if (en_cnt >= 5 && !stub_never) fft_valid = 1'b1;
    end else begin
      en_cnt = 0;
      if (fft_valid) begin
        if (stale_cnt >= 3) fft_valid = 1'b0;
        else stale_cnt = stale_cnt + 1;
      end
    end
  end

  task automatic check_frame(input string tag);
    logic [16*FFT-1:0] tc;
    tc = time_coord;
    for (int i = 0; i < FFT; i++) begin
      checks++;
      if (tc[i*16 +: 16] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL %s slot%0d: got %0h expected %0h", tag, i, tc[i*16 +: 16], 16'(i + 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (fft_en !== 1'b0) begin errors++; $display("FAIL reset_fft_en: got %0b expected 0", fft_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    checks++; if (out_re !== 16'd0 || out_im !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0h/%0h expected 0/0", out_re, out_im); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Feeds samples 1..8; with gaps, in_valid idles a random 0..2 cycles between samples.
  task automatic feed_frame(input bit gaps);
    for (int i = 0; i < FFT; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collect_in_ready s%0d: got %0b expected 1", i, in_ready); end
      checks++; if (fft_en !== 1'b0) begin errors++; $display("FAIL collect_fft_en s%0d: got %0b expected 0", i, fft_en); end
      in_valid  = 1'b1;
      in_sample = 16'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (fft_en !== 1'b1) begin errors++; $display("FAIL fill_fft_en_latency: got %0b expected 1", fft_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %0b expected 0", in_ready); end
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL fill_state: got %0d expected 1", state_dbg); end
    check_frame("fill_frame");
  endtask

  // Offers a sample during RUN that must stall, and waits for DRAIN entry.
  task automatic wait_run();
    bit seen;
    seen      = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'h7777;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL run_in_ready c%0d: got %0b expected 0", c, in_ready); end
      checks++; if (fft_en !== 1'b1) begin errors++; $display("FAIL run_fft_en c%0d: got %0b expected 1", c, fft_en); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL run_drain_entry: got no out_valid expected out_valid within 40 cycles"); end
    checks++; if (fft_en !== 1'b0) begin errors++; $display("FAIL drain_fft_en: got %0b expected 0", fft_en); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL drain_state: got %0d expected 2", state_dbg); end
    check_frame("run_frame_hold");
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
  task automatic drain_frame(input int mode);
    logic [34:0] exp;
    bit done;
    exp_q.delete();
    for (int i = 0; i < OUT_BINS; i++) exp_q.push_back({3'(i), 16'(i * 10), 16'(-i)});
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL drain_valid_drop c%0d: got %0b expected 1", c, out_valid);
        break;
      end
      exp = exp_q[0];
      checks++;
      if (out_idx !== exp[34:32] || out_re !== exp[31:16] || out_im !== exp[15:0]) begin
        errors++;
        $display("FAIL drain_bin c%0d: got idx%0d re%0h im%0h expected idx%0d re%0h im%0h",
                 c, out_idx, out_re, out_im, exp[34:32], exp[31:16], exp[15:0]);
      end
      checks++;
      if (out_last !== (exp[34:32] == 3'(OUT_BINS - 1))) begin
        errors++;
        $display("FAIL drain_last idx%0d: got %0b expected %0b", exp[34:32], out_last, exp[34:32] == 3'(OUT_BINS - 1));
      end
      out_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done = 1'b1;
      end
      @(negedge clk);
      if (done) break;
    end
    out_ready = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL drain_complete: got %0d bins left expected 0", exp_q.size()); end
    exp_frames++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL post_out_idx: got %0d expected 0", out_idx); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL post_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL post_state: got %0d expected 0", state_dbg); end
    // A lingering fft_valid must not start another drain.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || fft_en !== 1'b0) begin errors++; $display("FAIL stale_valid c%0d: got ov%0b en%0b expected 0/0", c, out_valid, fft_en); end
    end
  endtask

  task automatic test_fill_and_drain();
    feed_frame(1'b0);
    wait_run();
    drain_frame(0);
  endtask

  task automatic test_backpressure();
    feed_frame(1'b1);
    wait_run();
    drain_frame(1);
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    seen = 1'b0;
    feed_frame(1'b0);
    wait_run();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1 && out_idx === 3'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_reach_idx2: got idx%0d expected 2", out_idx); end
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL midrst_out_idx: got %0d expected 0", out_idx); end
    @(negedge clk);
    @(negedge clk);
    test_fill_and_drain();
  endtask

`ifdef FFT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    stub_never = 1'b1;
    feed_frame(1'b0);
    n = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fft_en !== 1'b1) break;
      n++;
    end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_run_cycles: got %0d expected %0d", n, TIMEOUT); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %0b expected 1", timeout_err); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL timeout_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL timeout_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_out_valid: got %0b expected 0", out_valid); end
    stub_never = 1'b0;
    test_fill_and_drain();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %0b expected 1", timeout_err); end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    exp_frames = 0;
    stub_never = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sample  = 16'd0;
    out_ready  = 1'b0;
    for (int i = 0; i < FFT; i++) begin
      fft_re[i*16 +: 16] = 16'(i * 10);
      fft_im[i*16 +: 16] = 16'(-i);
    end

    test_reset();
    test_fill_and_drain();
    test_backpressure();
    test_reset_mid_frame();
`ifdef FFT_CTRL_TIMEOUT_EN
    test_timeout();
`else
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_tied: got %0b expected 0", timeout_err); end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
